// File: rtl/dl11_irq_arbiter.sv
// DL11 console interrupt arbiter: owns RCSR/XCSR IE bits, merges RX/TX ready into one IRQ, supplies vector at INTACK.
// Latency: cond rise -> pending 1 edge -> irq 1 edge; INTACK -> vector_valid next edge; bus_end -> release next edge.
// Backpressure: none; bus strobes are single-cycle pulses, and a request is held until acknowledged or withdrawn.
module dl11_irq_arbiter (
   input  logic        sys_clk,
   input  logic        RESET_n,
   input  logic        bus_write_stb,
   input  logic        bus_byte,
   input  logic        bus_intack_stb,
   input  logic        bus_end_stb,
   input  logic [15:0] bus_address,
   input  logic [15:0] bus_wdata,
   input  logic        rx_data_ready,
   input  logic        tx_ready,
   output logic        rcsr_ie,
   output logic        xcsr_ie,
   output logic        irq,
   output logic [15:0] vector,
   output logic        vector_valid
);

   localparam logic [15:0] RX_VECTOR = 16'o000060;
   localparam logic [15:0] TX_VECTOR = 16'o000064;
   localparam logic [15:0] ADRS_RCSR = 16'o177560;
   localparam logic [15:0] ADRS_XCSR = 16'o177564;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_VEC  = 2'd2;

   logic [1:0] state;
   logic       rx_cond, tx_cond;
   logic       rx_cond_d, tx_cond_d;
   logic       rx_pend, tx_pend;
   logic       rx_pend_nx, tx_pend_nx;
   logic       lane_lo, wr_rcsr, wr_xcsr;
   logic       ack, rx_grant, tx_grant;

   // Only bit 6 of the CSR write data is owned here; the rest belongs to the UART CSR logic.
   logic unused_wdata;
   assign unused_wdata = ^{bus_wdata[15:7], bus_wdata[5:0]};

   // IE lives in the low byte. A word write covers the whole register; a byte write
   // only reaches it when it targets the even (low) byte.
   assign lane_lo = ~(bus_byte & bus_address[0]);
   assign wr_rcsr = bus_write_stb & lane_lo & (bus_address[15:1] == ADRS_RCSR[15:1]);
   assign wr_xcsr = bus_write_stb & lane_lo & (bus_address[15:1] == ADRS_XCSR[15:1]);

   assign rx_cond = rx_data_ready & rcsr_ie;
   assign tx_cond = tx_ready & xcsr_ie;

   // Winner is picked from the pendings seen at the INTACK cycle, RX first.
   assign ack      = bus_intack_stb & (state == S_REQ);
   assign rx_grant = ack & rx_pend;
   assign tx_grant = ack & ~rx_pend & tx_pend;

   // Pending next-state: rising edge sets; dropped cond or grant clears; set beats clear.
   always_comb begin
      rx_pend_nx = (rx_cond & ~rx_cond_d) | (rx_pend & rx_cond & ~rx_grant);
      tx_pend_nx = (tx_cond & ~tx_cond_d) | (tx_pend & tx_cond & ~tx_grant);
   end

   // Interrupt-enable bits, written through the CSR addresses.
   always_ff @(posedge sys_clk) begin
      if (!RESET_n) begin
         rcsr_ie <= 1'b0;
         xcsr_ie <= 1'b0;
      end else begin
         if (wr_rcsr) rcsr_ie <= bus_wdata[6];
         if (wr_xcsr) xcsr_ie <= bus_wdata[6];
      end
   end

   // Edge-detect history and pending flags for both sources.
   always_ff @(posedge sys_clk) begin
      if (!RESET_n) begin
         rx_cond_d <= 1'b0;
         tx_cond_d <= 1'b0;
         rx_pend   <= 1'b0;
         tx_pend   <= 1'b0;
      end else begin
         rx_cond_d <= rx_cond;
         tx_cond_d <= tx_cond;
         rx_pend   <= rx_pend_nx;
         tx_pend   <= tx_pend_nx;
      end
   end

   // Request / acknowledge sequencer with registered irq, vector and vector_valid.
   always_ff @(posedge sys_clk) begin
      if (!RESET_n) begin
         state        <= S_IDLE;
         irq          <= 1'b0;
         vector       <= 16'd0;
         vector_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rx_pend | tx_pend) begin
                  state <= S_REQ;
                  irq   <= 1'b1;
               end
            end
            S_REQ: begin
               // INTACK is checked first: once the CPU has started the cycle a
               // vector must be supplied, even if it is 0 because the request vanished.
               if (bus_intack_stb) begin
                  if (rx_pend)      vector <= RX_VECTOR;
                  else if (tx_pend) vector <= TX_VECTOR;
                  else              vector <= 16'd0;
                  state        <= S_VEC;
                  irq          <= 1'b0;
                  vector_valid <= 1'b1;
               end else if (!rx_pend && !tx_pend) begin
                  state <= S_IDLE;
                  irq   <= 1'b0;
               end
            end
            S_VEC: begin
               if (bus_end_stb) begin
                  state        <= S_IDLE;
                  vector_valid <= 1'b0;
               end
            end
            default: begin
               state        <= S_IDLE;
               irq          <= 1'b0;
               vector_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dl11_irq_arbiter.sv
// Directed bench for dl11_irq_arbiter: vector table of {inputs, expected outputs} plus hand sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-derived from the cycle timing of the block.
module tb_dl11_irq_arbiter;

   localparam logic [15:0] RCSR = 16'o177560;
   localparam logic [15:0] XCSR = 16'o177564;

   logic        sys_clk;
   logic        RESET_n;
   logic        bus_write_stb, bus_byte, bus_intack_stb, bus_end_stb;
   logic [15:0] bus_address, bus_wdata;
   logic        rx_data_ready, tx_ready;
   logic        rcsr_ie, xcsr_ie, irq, vector_valid;
   logic [15:0] vector;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        rst_n, wr, byt, ia, en;
      logic [15:0] addr, wd;
      logic        rx, tx;
      logic        e_rie, e_xie, e_irq, e_vv;
      logic [15:0] e_vec;
      logic        chk_vec;
   } vec_t;

   vec_t tbl[$];

   dl11_irq_arbiter dut (
      .sys_clk        (sys_clk),
      .RESET_n        (RESET_n),
      .bus_write_stb  (bus_write_stb),
      .bus_byte       (bus_byte),
      .bus_intack_stb (bus_intack_stb),
      .bus_end_stb    (bus_end_stb),
      .bus_address    (bus_address),
      .bus_wdata      (bus_wdata),
      .rx_data_ready  (rx_data_ready),
      .tx_ready       (tx_ready),
      .rcsr_ie        (rcsr_ie),
      .xcsr_ie        (xcsr_ie),
      .irq            (irq),
      .vector         (vector),
      .vector_valid   (vector_valid)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0o expected %0o", name, act, exp);
      end
   endtask

   task automatic v(input logic rst_n, wr, byt, ia, en, input logic [15:0] addr, wd,
                    input logic rx, tx, input logic e_rie, e_xie, e_irq, e_vv,
                    input logic [15:0] e_vec, input logic chk_vec);
      vec_t t;
      t.rst_n = rst_n; t.wr = wr; t.byt = byt; t.ia = ia; t.en = en;
      t.addr = addr; t.wd = wd; t.rx = rx; t.tx = tx;
      t.e_rie = e_rie; t.e_xie = e_xie; t.e_irq = e_irq; t.e_vv = e_vv;
      t.e_vec = e_vec; t.chk_vec = chk_vec;
      tbl.push_back(t);
   endtask

   // Drive one cycle of inputs on the falling edge, then wait past the rising edge.
   task automatic drv(input logic rst_n, wr, byt, ia, en, input logic [15:0] addr, wd,
                      input logic rx, tx);
      @(negedge sys_clk);
      RESET_n = rst_n; bus_write_stb = wr; bus_byte = byt; bus_intack_stb = ia;
      bus_end_stb = en; bus_address = addr; bus_wdata = wd;
      rx_data_ready = rx; tx_ready = tx;
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      logic found;
      RESET_n = 1'b0; bus_write_stb = 1'b0; bus_byte = 1'b0; bus_intack_stb = 1'b0;
      bus_end_stb = 1'b0; bus_address = 16'd0; bus_wdata = 16'd0;
      rx_data_ready = 1'b1; tx_ready = 1'b0;

      //  rst wr by ia en  addr       wdata      rx tx  rie xie irq vv  vector     chk
      // reset held with rx ready, then released with IE=0
      v(0, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  0, 0, 0, 0, 16'd0,     1);
      v(0, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  0, 0, 0, 0, 16'd0,     1);
      v(0, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  0, 0, 0, 0, 16'd0,     1);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  0, 0, 0, 0, 16'd0,     1);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  0, 0, 0, 0, 16'd0,     1);
      // RX interrupt
      v(1, 1, 0, 0, 0, RCSR,      16'o100,   0, 0,  1, 0, 0, 0, 16'd0,     1);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  1, 0, 0, 0, 16'd0,     1);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  1, 0, 1, 0, 16'd0,     1);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  1, 0, 1, 0, 16'd0,     1);
      v(1, 0, 0, 1, 0, 16'd0,     16'd0,     1, 0,  1, 0, 0, 1, 16'o000060, 1);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  1, 0, 0, 1, 16'o000060, 1);
      v(1, 0, 0, 0, 1, 16'd0,     16'd0,     1, 0,  1, 0, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  1, 0, 0, 0, 16'd0,     0);
      // dual request: RX first, TX after a one-cycle irq gap
      v(1, 1, 0, 0, 0, XCSR,      16'o100,   0, 0,  1, 1, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 1,  1, 1, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 1,  1, 1, 1, 0, 16'd0,     0);
      v(1, 0, 0, 1, 0, 16'd0,     16'd0,     1, 1,  1, 1, 0, 1, 16'o000060, 1);
      v(1, 0, 0, 0, 1, 16'd0,     16'd0,     1, 1,  1, 1, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 1,  1, 1, 1, 0, 16'd0,     0);
      v(1, 0, 0, 1, 0, 16'd0,     16'd0,     1, 1,  1, 1, 0, 1, 16'o000064, 1);
      v(1, 0, 0, 0, 1, 16'd0,     16'd0,     1, 1,  1, 1, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 1,  1, 1, 0, 0, 16'd0,     0);
      // IE set while TX already ready; odd-byte write ignored
      v(1, 1, 0, 0, 0, RCSR,      16'd0,     0, 1,  0, 1, 0, 0, 16'd0,     0);
      v(1, 1, 0, 0, 0, XCSR,      16'd0,     0, 1,  0, 0, 0, 0, 16'd0,     0);
      v(1, 1, 1, 0, 0, 16'o177565, 16'o100,  0, 1,  0, 0, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     0, 1,  0, 0, 0, 0, 16'd0,     0);
      v(1, 1, 0, 0, 0, XCSR,      16'o100,   0, 1,  0, 1, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     0, 1,  0, 1, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     0, 1,  0, 1, 1, 0, 16'd0,     0);
      v(1, 0, 0, 1, 0, 16'd0,     16'd0,     0, 1,  0, 1, 0, 1, 16'o000064, 1);
      v(1, 0, 0, 0, 1, 16'd0,     16'd0,     0, 1,  0, 1, 0, 0, 16'd0,     0);
      v(1, 1, 0, 0, 0, XCSR,      16'd0,     0, 1,  0, 0, 0, 0, 16'd0,     0);
      // withdrawal before INTACK, then a spurious INTACK
      v(1, 1, 0, 0, 0, RCSR,      16'o100,   0, 1,  1, 0, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 1,  1, 0, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 1,  1, 0, 1, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     0, 1,  1, 0, 1, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     0, 1,  1, 0, 0, 0, 16'd0,     0);
      v(1, 0, 0, 1, 0, 16'd0,     16'd0,     0, 1,  1, 0, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     0, 1,  1, 0, 0, 0, 16'd0,     0);
      // reset while in VEC
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 1,  1, 0, 0, 0, 16'd0,     0);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 1,  1, 0, 1, 0, 16'd0,     0);
      v(1, 0, 0, 1, 0, 16'd0,     16'd0,     1, 1,  1, 0, 0, 1, 16'o000060, 1);
      v(0, 0, 0, 0, 0, 16'd0,     16'd0,     1, 1,  0, 0, 0, 0, 16'd0,     1);
      v(1, 0, 0, 0, 0, 16'd0,     16'd0,     1, 0,  0, 0, 0, 0, 16'd0,     1);

      foreach (tbl[i]) begin
         drv(tbl[i].rst_n, tbl[i].wr, tbl[i].byt, tbl[i].ia, tbl[i].en,
             tbl[i].addr, tbl[i].wd, tbl[i].rx, tbl[i].tx);
         chk($sformatf("v%0d rcsr_ie", i), {15'd0, rcsr_ie}, {15'd0, tbl[i].e_rie});
         chk($sformatf("v%0d xcsr_ie", i), {15'd0, xcsr_ie}, {15'd0, tbl[i].e_xie});
         chk($sformatf("v%0d irq", i), {15'd0, irq}, {15'd0, tbl[i].e_irq});
         chk($sformatf("v%0d vector_valid", i), {15'd0, vector_valid}, {15'd0, tbl[i].e_vv});
         if (tbl[i].chk_vec)
            chk($sformatf("v%0d vector", i), vector, tbl[i].e_vec);
      end

      // INTACK arriving in REQ after the request has been withdrawn: vector 0 is supplied.
      drv(1, 1, 0, 0, 0, RCSR, 16'o100, 0, 0);
      chk("h1 rcsr_ie", {15'd0, rcsr_ie}, 16'd1);
      drv(1, 0, 0, 0, 0, 16'd0, 16'd0, 1, 0);
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         drv(1, 0, 0, 0, 0, 16'd0, 16'd0, 1, 0);
         if (irq) begin
            found = 1'b1;
            break;
         end
      end
      chk("h1 irq_wait", {15'd0, found}, 16'd1);
      drv(1, 0, 0, 0, 0, 16'd0, 16'd0, 0, 0);
      chk("h1 irq_held", {15'd0, irq}, 16'd1);
      drv(1, 0, 0, 1, 0, 16'd0, 16'd0, 0, 0);
      chk("h1 late_ack_vv", {15'd0, vector_valid}, 16'd1);
      chk("h1 late_ack_vector", vector, 16'd0);
      chk("h1 late_ack_irq", {15'd0, irq}, 16'd0);
      drv(1, 0, 0, 0, 1, 16'd0, 16'd0, 0, 0);
      chk("h1 release_vv", {15'd0, vector_valid}, 16'd0);
      drv(1, 0, 0, 0, 0, 16'd0, 16'd0, 0, 0);
      chk("h1 idle_irq", {15'd0, irq}, 16'd0);

      // Clearing IE during REQ: pending drops one edge later, irq one edge after that.
      drv(1, 0, 0, 0, 0, 16'd0, 16'd0, 1, 0);
      chk("h2 irq_pre", {15'd0, irq}, 16'd0);
      drv(1, 0, 0, 0, 0, 16'd0, 16'd0, 1, 0);
      chk("h2 irq_up", {15'd0, irq}, 16'd1);
      drv(1, 1, 0, 0, 0, RCSR, 16'd0, 1, 0);
      chk("h2 ie_cleared", {15'd0, rcsr_ie}, 16'd0);
      chk("h2 irq_at_write", {15'd0, irq}, 16'd1);
      drv(1, 0, 0, 0, 0, 16'd0, 16'd0, 1, 0);
      chk("h2 irq_plus1", {15'd0, irq}, 16'd1);
      drv(1, 0, 0, 0, 0, 16'd0, 16'd0, 1, 0);
      chk("h2 irq_plus2", {15'd0, irq}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
